// File: rtl/multi_run_counter.sv
// Bank of NCH independent run counters with per-channel terminal value and mode (wrap/saturate/one-shot).
// Optional shared advance prescaler is built only when RUN_CTR_PRESCALE_EN is defined.
module multi_run_counter #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH-1:0]       ch_load,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic [NCH*WIDTH-1:0] term_val,
  input  logic [2*NCH-1:0]     mode,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       tc_pulse,
  output logic [NCH-1:0]       done,
  output logic                 all_done
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SAT  = 2'd1,
    ST_STOP = 2'd2
  } ch_state_e;

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONES = 2'b10;

  // Per-channel state is kept as a named array so checkers can bind to it.
  ch_state_e        ch_state   [NCH];
  ch_state_e        ch_state_d [NCH];
  logic [WIDTH-1:0] count_q    [NCH];
  logic [WIDTH-1:0] count_d    [NCH];
  logic [NCH-1:0]   done_q, done_d;
  logic [NCH-1:0]   tc_q, tc_d;
  logic             tick;

`ifdef RUN_CTR_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign tick = (pre_q == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  // State register: channel FSMs and datapath share one clocked process.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        ch_state[i] <= ST_RUN;
        count_q[i]  <= '0;
      end
      done_q <= '0;
      tc_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ch_state[i] <= ch_state_d[i];
        count_q[i]  <= count_d[i];
      end
      done_q <= done_d;
      tc_q   <= tc_d;
    end
  end

  // Next-state logic: load beats advance; an advance at the terminal value is the terminal event.
  always_comb begin
    done_d = done_q;
    tc_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_state_d[i] = ch_state[i];
      count_d[i]    = count_q[i];
      if (ch_load[i]) begin
        count_d[i]    = load_val[i*WIDTH +: WIDTH];
        ch_state_d[i] = ST_RUN;
        done_d[i]     = 1'b0;
      end else if (ch_en[i] && tick && (ch_state[i] == ST_RUN)) begin
        if (count_q[i] == term_val[i*WIDTH +: WIDTH]) begin
          tc_d[i]   = 1'b1;
          done_d[i] = 1'b1;
          case (mode[i*2 +: 2])
            MODE_SAT:  ch_state_d[i] = ST_SAT;
            MODE_ONES: ch_state_d[i] = ST_STOP;
            default:   count_d[i]    = '0;
          endcase
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Output logic: pack per-channel registers onto the flat ports.
  always_comb begin
    count = '0;
    for (int i = 0; i < NCH; i++) begin
      count[i*WIDTH +: WIDTH] = count_q[i];
    end
    tc_pulse = tc_q;
    done     = done_q;
    all_done = &done_q;
  end

endmodule

// File: tb/tb_multi_run_counter.sv
// Self-checking bench for multi_run_counter: directed scenarios plus randomized traffic against a reference model.
// Works with or without RUN_CTR_PRESCALE_EN; directed expectations scale by the tick period.
module tb_multi_run_counter;
  localparam int NCH      = 4;
  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
`ifdef RUN_CTR_PRESCALE_EN
  localparam int TP = PRESCALE;
`else
  localparam int TP = 1;
`endif
  localparam int VW = NCH*WIDTH + 2*NCH + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]       ch_en = '0;
  logic [NCH-1:0]       ch_load = '0;
  logic [NCH*WIDTH-1:0] load_val = '0;
  logic [NCH*WIDTH-1:0] term_val = '0;
  logic [2*NCH-1:0]     mode = '0;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       tc_pulse;
  logic [NCH-1:0]       done;
  logic                 all_done;

  multi_run_counter #(.NCH(NCH), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .ch_load(ch_load),
    .load_val(load_val), .term_val(term_val), .mode(mode),
    .count(count), .tc_pulse(tc_pulse), .done(done), .all_done(all_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: counts as integers, a channel is either live or frozen
  int m_count [NCH];
  bit m_done  [NCH];
  bit m_tc    [NCH];
  bit m_frozen[NCH];
  int m_pre = 0;
  logic [VW-1:0] exp_q[$];

  function automatic void model_step();
    bit tk;
    int md;
    tk = (TP == 1) ? 1'b1 : (m_pre == TP - 1);
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        m_count[i] = 0; m_done[i] = 0; m_tc[i] = 0; m_frozen[i] = 0;
      end else if (ch_load[i]) begin
        m_count[i] = int'(load_val[i*WIDTH +: WIDTH]);
        m_done[i] = 0; m_tc[i] = 0; m_frozen[i] = 0;
      end else begin
        m_tc[i] = 0;
        if (ch_en[i] && tk && !m_frozen[i]) begin
          if (m_count[i] == int'(term_val[i*WIDTH +: WIDTH])) begin
            md = int'(mode[i*2 +: 2]);
            m_tc[i] = 1; m_done[i] = 1;
            if (md == 1 || md == 2) m_frozen[i] = 1;
            else m_count[i] = 0;
          end else begin
            m_count[i] = (m_count[i] + 1) % (1 << WIDTH);
          end
        end
      end
    end
    m_pre = reset ? 0 : (m_pre + 1) % TP;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NCH*WIDTH-1:0] c;
    logic [NCH-1:0] d, t;
    for (int i = 0; i < NCH; i++) begin
      c[i*WIDTH +: WIDTH] = WIDTH'(m_count[i]);
      d[i] = m_done[i];
      t[i] = m_tc[i];
    end
    return {&d, d, t, c};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {all_done, done, tc_pulse, count};
  endfunction

  function automatic logic [WIDTH-1:0] cnt(input int i);
    return count[i*WIDTH +: WIDTH];
  endfunction

  // driver: model advances with the same inputs the DUT samples, outputs read 1 unit after the edge
  task automatic step();
    model_step();
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_all(input logic [1:0] md, input logic [WIDTH-1:0] tv);
    for (int i = 0; i < NCH; i++) begin
      mode[i*2 +: 2] = md;
      term_val[i*WIDTH +: WIDTH] = tv;
    end
  endtask

  task automatic test_reset();
    ch_en = '1; ch_load = '0; set_all(2'b00, 8'd3);
    reset = 1'b1;
    step(); step();
    n_vec++;
    if (dut_vec() !== {VW{1'b0}}) begin
      n_err++; $display("FAIL reset_state got %h exp %h", dut_vec(), {VW{1'b0}});
    end
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [VW-1:0] e;
    ch_en = '0; set_all(2'b00, 8'd3);
    do_reset();
    ch_en = '1;
    for (int k = 1; k <= 12*TP; k++) begin
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (dut_vec() !== e) begin
        n_err++; $display("FAIL wrap_model k=%0d got %h exp %h", k, dut_vec(), e);
      end
      n_vec++;
      if (cnt(0) !== WIDTH'((k / TP) % 4) || tc_pulse[0] !== (k % TP == 0 && (k / TP) % 4 == 0)
          || done[0] !== (k >= 4*TP)) begin
        n_err++; $display("FAIL wrap_seq k=%0d got cnt=%0d tc=%b done=%b", k, cnt(0), tc_pulse[0], done[0]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [VW-1:0] e;
    int pulses = 0;
    ch_en = '0; set_all(2'b00, 8'd200);
    mode[2 +: 2] = 2'b01; term_val[WIDTH +: WIDTH] = 8'd5;
    do_reset();
    ch_en = 4'b0010;
    for (int k = 1; k <= 26*TP; k++) begin
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (dut_vec() !== e) begin
        n_err++; $display("FAIL sat_model k=%0d got %h exp %h", k, dut_vec(), e);
      end
      if (tc_pulse[1]) pulses++;
    end
    n_vec++;
    if (cnt(1) !== 8'd5 || done[1] !== 1'b1 || pulses != 1) begin
      n_err++; $display("FAIL sat_hold got cnt=%0d done=%b pulses=%0d exp 5 1 1", cnt(1), done[1], pulses);
    end
  endtask

  task automatic test_oneshot();
    logic [VW-1:0] e;
    ch_en = '0; set_all(2'b10, 8'd0);
    for (int i = 0; i < NCH; i++) term_val[i*WIDTH +: WIDTH] = WIDTH'(i + 2);
    do_reset();
    ch_en = '1;
    for (int k = 1; k <= 8*TP; k++) begin
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (dut_vec() !== e) begin
        n_err++; $display("FAIL oneshot_model k=%0d got %h exp %h", k, dut_vec(), e);
      end
      if (k == 6*TP - 1) begin
        n_vec++;
        if (all_done !== 1'b0 || done[3] !== 1'b0) begin
          n_err++; $display("FAIL oneshot_early got all_done=%b done3=%b exp 0 0", all_done, done[3]);
        end
      end
      if (k == 6*TP) begin
        n_vec++;
        if (all_done !== 1'b1 || done[3] !== 1'b1 || cnt(3) !== 8'd5) begin
          n_err++; $display("FAIL oneshot_all got all_done=%b done3=%b cnt3=%0d exp 1 1 5", all_done, done[3], cnt(3));
        end
      end
    end
    ch_en = '0; ch_load = 4'b0001; load_val[0 +: WIDTH] = 8'd1;
    step();
    e = exp_q.pop_front();
    ch_load = '0;
    n_vec++;
    if (done[0] !== 1'b0 || all_done !== 1'b0 || cnt(0) !== 8'd1 || dut_vec() !== e) begin
      n_err++; $display("FAIL oneshot_reload got %h exp %h", dut_vec(), e);
    end
  endtask

  task automatic test_load_priority();
    logic [VW-1:0] e;
    int m;
    ch_en = '0; set_all(2'b00, 8'h20);
    do_reset();
    ch_en = 4'b0100;
    for (int k = 1; k <= 7*TP; k++) step();
    n_vec++;
    if (cnt(2) !== 8'd7) begin
      n_err++; $display("FAIL load_pre got %0d exp 7", cnt(2));
    end
    for (int k = 1; k < TP; k++) step();
    ch_load = 4'b0100; load_val[2*WIDTH +: WIDTH] = 8'hF0; term_val[2*WIDTH +: WIDTH] = 8'h02;
    step();
    ch_load = '0;
    n_vec++;
    if (cnt(2) !== 8'hF0 || tc_pulse[2] !== 1'b0) begin
      n_err++; $display("FAIL load_prio got %h tc=%b exp f0 0", cnt(2), tc_pulse[2]);
    end
    exp_q.delete();
    for (m = 1; m <= 8'h13; m++) begin
      for (int k = 0; k < TP; k++) begin
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (dut_vec() !== e) begin
          n_err++; $display("FAIL load_model m=%0d got %h exp %h", m, dut_vec(), e);
        end
      end
      n_vec++;
      if (m < 8'h13 && (cnt(2) !== WIDTH'(8'hF0 + m) || tc_pulse[2] !== 1'b0)) begin
        n_err++; $display("FAIL load_wrap m=%0d got %h tc=%b", m, cnt(2), tc_pulse[2]);
      end else if (m == 8'h13 && (cnt(2) !== 8'h00 || tc_pulse[2] !== 1'b1)) begin
        n_err++; $display("FAIL load_term got %h tc=%b exp 00 1", cnt(2), tc_pulse[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    ch_en = '0; set_all(2'b00, 8'd1);
    do_reset();
    ch_en = 4'b0001;
    while (!m_done[0] && guard < 100) begin step(); guard++; end
    term_val[0 +: WIDTH] = 8'h40;
    while (m_count[0] != 9 && guard < 200) begin step(); guard++; end
    n_vec++;
    if (guard >= 200 || cnt(0) !== 8'd9 || done[0] !== 1'b1) begin
      n_err++; $display("FAIL rmid_setup got cnt=%0d done=%b guard=%0d", cnt(0), done[0], guard);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (cnt(0) !== 8'd0 || done !== '0 || tc_pulse !== '0 || all_done !== 1'b0) begin
      n_err++; $display("FAIL rmid_clear got %h exp 0", dut_vec());
    end
    for (int k = 0; k < TP; k++) step();
    n_vec++;
    if (cnt(0) !== 8'd1) begin
      n_err++; $display("FAIL rmid_resume got %0d exp 1", cnt(0));
    end
    exp_q.delete();
  endtask

  task automatic test_term_zero();
    ch_en = '0; set_all(2'b00, 8'd0);
    do_reset();
    ch_en = 4'b1000;
    for (int k = 1; k <= 3*TP; k++) begin
      step();
      n_vec++;
      if (cnt(3) !== 8'd0 || tc_pulse[3] !== (k % TP == 0) || done[3] !== (k >= TP)) begin
        n_err++; $display("FAIL term0 k=%0d got cnt=%0d tc=%b done=%b", k, cnt(3), tc_pulse[3], done[3]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    ch_en = '0;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NCH; i++) begin
        ch_en[i] = ($urandom_range(0, 3) != 0);
        ch_load[i] = ($urandom_range(0, 15) == 0);
        load_val[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255))
                                                                  : WIDTH'($urandom_range(0, 12));
        if ($urandom_range(0, 7) == 0) begin
          term_val[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 10));
          mode[i*2 +: 2] = 2'($urandom_range(0, 3));
        end
      end
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (dut_vec() !== e) begin
        n_err++; $display("FAIL random k=%0d got %h exp %h", k, dut_vec(), e);
      end
    end
    reset = 1'b0; ch_load = '0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_load_priority();
    test_reset_mid();
    test_term_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_run_counter.md
Name: multi_run_counter

Overview:
- Parametrised bank of NCH independent run counters, each WIDTH bits, with per-channel terminal value and mode: wrap, saturate or one-shot.
- Serves as the test-sequencing and timeout engine in the core. It replaces single fixed-limit counters.
- Provides per-channel terminal-count pulses, sticky done flags and a global all_done for bench or firmware completion detection.

Parameters:
- NCH, 4, number of independent channels (≥1).
- WIDTH, 32, counter width in bits (≥2).
- PRESCALE, 4, advance-tick divisor. Used only when RUN_CTR_PRESCALE_EN is defined. Must be ≥1.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ch_en  in  NCH  per-channel count enable.
- ch_load  in  NCH  per-channel load strobe.
- load_val  in  NCH*WIDTH  load value; channel i occupies bits [i*WIDTH +: WIDTH].
- term_val  in  NCH*WIDTH  terminal value per channel, same packing.
- mode  in  2*NCH  per-channel mode [i*2 +: 2]: 00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- count  out  NCH*WIDTH  current count per channel.
- tc_pulse  out  NCH  one-cycle terminal-count pulse.
- done  out  NCH  sticky terminal-reached flag.
- all_done  out  1  AND of all done bits.

Behaviour:
- Reset (sync, active-high):
  - count=0, tc_pulse=0, done=0, all channel states RUN, prescaler=0.
  - all_done reads 0 after reset. Reset overrides every other input in the same cycle.
- Per-channel states:
  - RUN: counting.
  - SAT: saturated, holding at term.
  - STOP: one-shot finished.
- tick: 1 every cycle by default; gated by the prescaler when RUN_CTR_PRESCALE_EN is defined.
- An advance occurs on an edge where ch_en[i]=1, tick=1, state=RUN and ch_load[i]=0.
- On an advance with count != term_val: count <= count+1, modulo 2^WIDTH.
- On an advance with count == term_val (terminal event):
  - wrap/11: count <= 0, state stays RUN.
  - saturate: count holds term_val, state <= SAT.
  - one-shot: count holds term_val, state <= STOP.
  - All modes: tc_pulse[i] <= 1 for exactly the next cycle, and done[i] <= 1.
- tc_pulse[i] is 0 in every cycle not directly following a terminal event.
- In SAT or STOP, ch_en is ignored: no further advances, pulses or count change.
- ch_load[i]=1:
  - count <= load_val, state <= RUN, done[i] <= 0, tc_pulse[i] <= 0.
  - Load has priority over an advance in the same cycle. Load is not gated by tick.
- term_val and mode are sampled live every cycle; changing them mid-run takes effect on the next advance.
- Loaded count > term_val: channel counts up, wraps through 2^WIDTH-1 -> 0, then reaches term_val normally. No early terminal event.
- term_val == 0 in wrap mode: a terminal event occurs on every advance; count stays 0 and tc_pulse is high on consecutive cycles.
- all_done: combinational AND of the done registers, so it is valid the same cycle done updates.
- Latency: count and done update one edge after the enabling inputs.
- Channels are fully independent; no cross-channel interaction except all_done.

Optional Feature:
- Macro: RUN_CTR_PRESCALE_EN.
- Defined:
  - Shared free-running prescaler counts 0..PRESCALE-1. tick=1 only when the prescaler equals PRESCALE-1.
  - Prescaler resets to 0 on reset.
  - PRESCALE=1 gives tick every cycle.
  - ch_en must be high on the tick cycle for an advance to occur.
- Not defined: no prescaler logic is built; tick is constant 1; PRESCALE is ignored.

Test Plan:
- Wrap mode: NCH=4, WIDTH=8, term=3, ch_en=1 after reset.
  - count runs 0,1,2,3,0,1…
  - tc_pulse is high the cycle count shows 0 after 3, repeating every 4 cycles.
  - done=1 from the first terminal event onward.
- Saturate mode on ch1, term=5:
  - count reaches 5 and holds; one tc_pulse; done[1]=1.
  - Keeping ch_en high for 20 further cycles gives no change.
- One-shot on all channels, term=2,3,4,5, all enabled together:
  - all_done rises in the same cycle done[3] sets, 6 edges after enable.
  - Load on ch0 then clears done[0] and all_done.
- Load with ch_en=1 in the same cycle at count=7:
  - count <= load_val=0xF0, not 8.
  - With term=0x02 the channel wraps 0xFF->0x00, then pulses after 0x02.
- Reset asserted mid-count at count=9 with done=1:
  - Next cycle count=0, done=0, tc_pulse=0, all_done=0, state RUN.
  - Counting resumes from 0 after reset deasserts.
- Prescale, with RUN_CTR_PRESCALE_EN defined, PRESCALE=4, term=2, wrap:
  - count increments once per 4 cycles; first tc_pulse follows the 3rd tick.
  - Without the macro, the same stimulus increments every cycle.
